// File: rtl/rx_agc_ctrl.sv
// Closed-loop receive AGC: dwell/decide/settle loop driving a PGA gain code from ADC RSSI words.
// Optional fast attack on over-range is built when RX_AGC_FAST_ATTACK_EN is defined.
module rx_agc_ctrl #(
    parameter logic [6:0] ADDR_BASE  = 7'd64,
    parameter int         GAIN_W     = 5,
    parameter int         GAIN_MAX   = 20,
    parameter int         SETTLE_CYC = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [6:0]        serial_addr,
    input  logic [31:0]       serial_data,
    input  logic              serial_strobe,
    input  logic [31:0]       rssi_in,
    output logic [GAIN_W-1:0] gain,
    output logic              gain_strobe,
    output logic [1:0]        agc_state,
    output logic              locked
);

    localparam int SC_W = $clog2(SETTLE_CYC + 1);
    localparam logic [GAIN_W:0]   GAIN_MAX_X = (GAIN_W+1)'(GAIN_MAX);
    localparam logic [GAIN_W-1:0] GAIN_MAX_G = GAIN_W'(GAIN_MAX);
    localparam logic [SC_W-1:0]   SETTLE_END = SC_W'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2,
        DECIDE  = 2'd3
    } agc_state_t;

    // Setting registers
    logic              agc_on_reg;
    logic              freeze_reg;
    logic [GAIN_W-1:0] manual_gain_reg;
    logic [15:0]       thresh_hi_reg;
    logic [15:0]       thresh_lo_reg;
    logic [15:0]       dwell_reg;
    logic [3:0]        step_reg;
    logic [2:0]        wr_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_wr_sel
            assign wr_sel[gi] = serial_strobe && (serial_addr == ADDR_BASE + 7'(gi));
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            agc_on_reg      <= 1'b0;
            freeze_reg      <= 1'b0;
            manual_gain_reg <= '0;
            thresh_hi_reg   <= '0;
            thresh_lo_reg   <= '0;
            dwell_reg       <= '0;
            step_reg        <= '0;
        end else begin
            if (wr_sel[0]) begin
                agc_on_reg      <= serial_data[0];
                freeze_reg      <= serial_data[1];
                manual_gain_reg <= serial_data[8 +: GAIN_W];
            end
            if (wr_sel[1]) begin
                thresh_hi_reg <= serial_data[31:16];
                thresh_lo_reg <= serial_data[15:0];
            end
            if (wr_sel[2]) begin
                dwell_reg <= serial_data[15:0];
                step_reg  <= serial_data[19:16];
            end
        end
    end

    // Loop state
    agc_state_t        state_reg, state_next;
    logic [GAIN_W-1:0] gain_reg, gain_next;
    logic              gain_strobe_reg, gain_strobe_next;
    logic              locked_reg, locked_next;
    logic [SC_W-1:0]   settle_cnt_reg, settle_cnt_next;
    logic [15:0]       dwell_cnt_reg, dwell_cnt_next;
    logic              clip_seen_reg, clip_seen_next;

    // Gain arithmetic is one bit wider than the code so underflow shows up as the top bit.
    logic [3:0]        step_eff;
    logic [GAIN_W:0]   step_x;
    logic [GAIN_W:0]   gain_x;
    logic [GAIN_W:0]   dec1;
    logic [GAIN_W:0]   inc1;
    logic [GAIN_W-1:0] dec1_sat;
    logic [GAIN_W-1:0] inc1_sat;
    logic [GAIN_W-1:0] manual_clamped;
    logic [16:0]       dwell_eff;
    logic [16:0]       dwell_cnt_inc;
    logic              clip_now;
    logic              dec_req;
    logic              inc_req;
    logic [GAIN_W-1:0] target;

    assign step_eff       = (step_reg == 4'd0) ? 4'd1 : step_reg;
    assign step_x         = (GAIN_W+1)'(step_eff);
    assign gain_x         = {1'b0, gain_reg};
    assign dec1           = gain_x - step_x;
    assign inc1           = gain_x + step_x;
    assign dec1_sat       = dec1[GAIN_W] ? '0 : dec1[GAIN_W-1:0];
    assign inc1_sat       = (inc1 > GAIN_MAX_X) ? GAIN_MAX_G : inc1[GAIN_W-1:0];
    assign manual_clamped = ({1'b0, manual_gain_reg} > GAIN_MAX_X) ? GAIN_MAX_G : manual_gain_reg;
    assign dwell_eff      = (dwell_reg == 16'd0) ? 17'd1 : {1'b0, dwell_reg};
    assign dwell_cnt_inc  = {1'b0, dwell_cnt_reg} + 17'd1;
    assign clip_now       = (rssi_in[31:16] != 16'd0);

    // Decrement wins, which also resolves an inverted threshold window.
    assign dec_req = clip_seen_reg || (rssi_in[15:0] > thresh_hi_reg);
    assign inc_req = !dec_req && (rssi_in[15:0] < thresh_lo_reg);
    assign target  = dec_req ? dec1_sat : (inc_req ? inc1_sat : gain_reg);

`ifdef RX_AGC_FAST_ATTACK_EN
    logic [GAIN_W:0]   dec2;
    logic [GAIN_W-1:0] dec2_sat;
    assign dec2     = gain_x - {step_x[GAIN_W-1:0], 1'b0};
    assign dec2_sat = dec2[GAIN_W] ? '0 : dec2[GAIN_W-1:0];
`endif

    always_comb begin
        state_next       = state_reg;
        gain_next        = gain_reg;
        gain_strobe_next = 1'b0;
        locked_next      = locked_reg;
        settle_cnt_next  = settle_cnt_reg;
        dwell_cnt_next   = dwell_cnt_reg;
        clip_seen_next   = clip_seen_reg;

        if (state_reg != IDLE && !agc_on_reg) begin
            state_next  = IDLE;
            locked_next = 1'b0;
        end else if (!freeze_reg) begin
            case (state_reg)
                IDLE: begin
                    locked_next = 1'b0;
                    if (agc_on_reg) begin
                        state_next      = SETTLE;
                        settle_cnt_next = '0;
                    end else if (manual_clamped != gain_reg) begin
                        gain_next        = manual_clamped;
                        gain_strobe_next = 1'b1;
                    end
                end
                SETTLE: begin
                    if (enable) begin
                        if (settle_cnt_reg == SETTLE_END) begin
                            state_next     = MEASURE;
                            dwell_cnt_next = '0;
                            clip_seen_next = 1'b0;
                        end else begin
                            settle_cnt_next = settle_cnt_reg + 1'b1;
                        end
                    end
                end
                MEASURE: begin
                    if (enable) begin
`ifdef RX_AGC_FAST_ATTACK_EN
                        if (clip_now && gain_reg != '0) begin
                            gain_next        = dec2_sat;
                            gain_strobe_next = 1'b1;
                            locked_next      = 1'b0;
                            state_next       = SETTLE;
                            settle_cnt_next  = '0;
                        end else begin
                            clip_seen_next = clip_seen_reg | clip_now;
                            dwell_cnt_next = dwell_cnt_inc[15:0];
                            if (dwell_cnt_inc >= dwell_eff)
                                state_next = DECIDE;
                        end
`else
                        clip_seen_next = clip_seen_reg | clip_now;
                        dwell_cnt_next = dwell_cnt_inc[15:0];
                        if (dwell_cnt_inc >= dwell_eff)
                            state_next = DECIDE;
`endif
                    end
                end
                DECIDE: begin
                    locked_next = !dec_req && !inc_req;
                    if (target != gain_reg) begin
                        gain_next        = target;
                        gain_strobe_next = 1'b1;
                        state_next       = SETTLE;
                        settle_cnt_next  = '0;
                    end else begin
                        state_next     = MEASURE;
                        dwell_cnt_next = '0;
                        clip_seen_next = 1'b0;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= IDLE;
            gain_reg        <= '0;
            gain_strobe_reg <= 1'b0;
            locked_reg      <= 1'b0;
            settle_cnt_reg  <= '0;
            dwell_cnt_reg   <= '0;
            clip_seen_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            gain_reg        <= gain_next;
            gain_strobe_reg <= gain_strobe_next;
            locked_reg      <= locked_next;
            settle_cnt_reg  <= settle_cnt_next;
            dwell_cnt_reg   <= dwell_cnt_next;
            clip_seen_reg   <= clip_seen_next;
        end
    end

    assign gain        = gain_reg;
    assign gain_strobe = gain_strobe_reg;
    assign agc_state   = state_reg;
    assign locked      = locked_reg;

endmodule
